// File: rtl/uart_pkg.sv
// Shared UART definitions: frame states, bit-period helper and line idle level.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam logic UART_IDLE = 1'b1;

    // Clock cycles per bit, rounded to nearest.
    function automatic int unsigned uart_div(input int unsigned clk_freq,
                                             input int unsigned baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: one-cycle registered tick every DIV cycles, synchronous clear.
module uart_baud_gen #(
    parameter int unsigned DIV = 10
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int unsigned   CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clear || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    // Tick is registered so it is high exactly while the count sits at DIV-1.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= (cnt_d == LAST);
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a byte FIFO into 8N1 UART frames; define FIFO_UART_TX_PARITY_EN for 8E1.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 27_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_read_en,
    output logic                  tx,
    output logic                  busy
);

    localparam int unsigned   DIV      = uart_div(CLK_FREQ, BAUD);
    localparam int unsigned   IW       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IW-1:0] LAST_BIT = IW'(DATA_WIDTH - 1);

    if (DIV < 2) begin : g_div_check
        $error("fifo_uart_tx: bit period DIV=%0d is below 2", DIV);
    end

    uart_state_e           state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [IW-1:0]         idx_q, idx_d, idx_inc;
    logic                  tx_q, tx_d;
    logic                  rd_q, rd_d;
    logic                  busy_q, busy_d;
    logic                  baud_clear;
    logic                  tick;

    // Counter is held cleared in IDLE so every frame starts on a fresh bit period.
    assign baud_clear = (state_q == ST_IDLE);

    uart_baud_gen #(
        .DIV (DIV)
    ) u_baud (
        .clock (clock),
        .reset (reset),
        .clear (baud_clear),
        .tick  (tick)
    );

    assign idx_inc = idx_q + IW'(1);

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        tx_d    = tx_q;
        rd_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tx_d = UART_IDLE;
                // Data latched on the same edge that raises read_en, before the FIFO advances.
                if (!fifo_empty) begin
                    shift_d = fifo_data;
                    rd_d    = 1'b1;
                    tx_d    = 1'b0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    idx_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (idx_q == LAST_BIT) begin
`ifdef FIFO_UART_TX_PARITY_EN
                        tx_d    = ^shift_q;
                        state_d = ST_PARITY;
`else
                        tx_d    = UART_IDLE;
                        state_d = ST_STOP;
`endif
                    end else begin
                        idx_d = idx_inc;
                        tx_d  = shift_q[idx_inc];
                    end
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    tx_d    = UART_IDLE;
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    tx_d    = UART_IDLE;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                tx_d    = UART_IDLE;
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            tx_q    <= UART_IDLE;
            rd_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            rd_q    <= rd_d;
            busy_q  <= busy_d;
        end
    end

    assign fifo_read_en = rd_q;
    assign tx           = tx_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx against a behavioural 16-deep FIFO; frames decoded from tx into a scoreboard.
`timescale 1ns/1ps
module tb_fifo_uart_tx;

    localparam int unsigned CLK_FREQ = 1_000_000;
    localparam int unsigned BAUD     = 100_000;
    localparam int unsigned DW       = 8;
    localparam int unsigned DIV      = 10;
    localparam int unsigned DEPTH    = 16;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int unsigned NBITS = DW + 3;
    localparam bit          PAR   = 1'b1;
`else
    localparam int unsigned NBITS = DW + 2;
    localparam bit          PAR   = 1'b0;
`endif
    localparam int unsigned FRAME = NBITS * DIV;

    logic          clock = 1'b0;
    logic          reset;
    logic          fifo_rst;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          fifo_empty;
    logic          fifo_full;
    logic [DW-1:0] fifo_data;
    logic          fifo_read_en;
    logic          tx;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    fifo_uart_tx #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .DATA_WIDTH (DW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .fifo_empty   (fifo_empty),
        .fifo_data    (fifo_data),
        .fifo_read_en (fifo_read_en),
        .tx           (tx),
        .busy         (busy)
    );

    // FIFO model: pops on a rising edge of read_en, head shown combinationally.
    logic [DW-1:0] mem [DEPTH];
    logic [3:0]    wptr, rptr;
    logic [4:0]    cnt;
    logic          rd_prev_f;
    wire           do_wr = wr_en && !fifo_full;
    wire           do_rd = fifo_read_en && !rd_prev_f && !fifo_empty;

    assign fifo_empty = (cnt == 5'd0);
    assign fifo_full  = (cnt == 5'(DEPTH));
    assign fifo_data  = mem[rptr];

    always @(posedge clock) begin
        if (fifo_rst) begin
            wptr      <= '0;
            rptr      <= '0;
            cnt       <= '0;
            rd_prev_f <= 1'b0;
        end else begin
            rd_prev_f <= fifo_read_en;
            if (do_wr) begin
                mem[wptr] <= wr_data;
                wptr      <= wptr + 4'd1;
            end
            if (do_rd) rptr <= rptr + 4'd1;
            cnt <= cnt + 5'(do_wr) - 5'(do_rd);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard and monitor state
    logic [DW-1:0] exp_q[$];
    int            start_cyc[$];
    int            cyc = 0;
    int            t = 0;
    logic          in_frame = 1'b0;
    logic [DW-1:0] rx;
    logic          last_par = 1'b0;
    logic          prev_empty = 1'b1;
    logic          rd_prev = 1'b0;
    int            pulses = 0;
    int            viol = 0;
    int            busy_run = 0;
    int            last_busy_len = 0;

    initial begin
        logic [DW-1:0] e;
        forever begin
            @(negedge clock);
            cyc++;
            if (fifo_read_en) begin
                if (rd_prev) viol++;
                else pulses++;
            end
            if (busy) busy_run++;
            else if (busy_run != 0) begin
                last_busy_len = busy_run;
                busy_run      = 0;
            end
            if (in_frame && !busy) begin
                in_frame = 1'b0;
            end else if (!in_frame) begin
                if (!tx && !reset) begin
                    in_frame = 1'b1;
                    t        = 0;
                    rx       = '0;
                    start_cyc.push_back(cyc);
                    check("sof_read_en", 32'(fifo_read_en), 32'd1);
                    check("sof_busy", 32'(busy), 32'd1);
                    check("sof_empty_prev", 32'(prev_empty), 32'd0);
                end
            end else begin
                t++;
                if (t == 1) check("read_en_width", 32'(fifo_read_en), 32'd0);
                if (t == DIV / 2) check("start_bit", 32'(tx), 32'd0);
                for (int i = 0; i < DW; i++) begin
                    if (t == DIV / 2 + DIV * (i + 1)) rx[i] = tx;
                end
                if (PAR && (t == DIV / 2 + DIV * (DW + 1))) last_par = tx;
                if (t == DIV / 2 + DIV * (NBITS - 1)) begin
                    check("stop_bit", 32'(tx), 32'd1);
                    if (exp_q.size() == 0) begin
                        check("rx_frame_expected", 32'(exp_q.size() != 0), 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        check("rx_byte", 32'(rx), 32'(e));
                        if (PAR) check("rx_parity", 32'(last_par), 32'(^e));
                    end
                    in_frame = 1'b0;
                end
            end
            prev_empty = fifo_empty;
            rd_prev    = fifo_read_en;
        end
    end

    task automatic write_byte(input logic [DW-1:0] b, input bit track);
        wr_en   = 1'b1;
        wr_data = b;
        if (track) exp_q.push_back(b);
        @(negedge clock);
        wr_en = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || busy || !fifo_empty || in_frame) && n < budget) begin
            @(negedge clock);
            n++;
        end
        check(tag, 32'(n < budget), 32'd1);
        repeat (3) @(negedge clock);
    endtask

    initial begin
        int bad;
        int p0;
        int n;
        reset    = 1'b1;
        fifo_rst = 1'b1;
        wr_en    = 1'b0;
        wr_data  = '0;
        repeat (3) @(negedge clock);
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_read_en", 32'(fifo_read_en), 32'd0);

        // 0x55 queued while the transmitter is still in reset
        fifo_rst = 1'b0;
        @(negedge clock);
        write_byte(8'h55, 1'b1);
        bad = 0;
        repeat (3) begin
            @(negedge clock);
            if (fifo_read_en || !tx || busy) bad++;
        end
        check("held_in_reset", 32'(bad), 32'd0);
        p0    = pulses;
        reset = 1'b0;
        wait_done(400, "drain_55");
        check("len_55", 32'(last_busy_len), 32'(FRAME));
        check("pulses_55", 32'(pulses - p0), 32'd1);
        check("empty_after_55", 32'(fifo_empty), 32'd1);

        // back-to-back frames
        start_cyc.delete();
        p0 = pulses;
        write_byte(8'h01, 1'b1);
        write_byte(8'h80, 1'b1);
        write_byte(8'hFF, 1'b1);
        wait_done(800, "drain_b2b");
        check("b2b_starts", 32'(start_cyc.size()), 32'd3);
        if (start_cyc.size() >= 3) begin
            check("b2b_gap01", 32'(start_cyc[1] - start_cyc[0]), 32'(FRAME + 1));
            check("b2b_gap12", 32'(start_cyc[2] - start_cyc[1]), 32'(FRAME + 1));
        end
        check("b2b_pulses", 32'(pulses - p0), 32'd3);

        // long idle with an empty FIFO
        bad = 0;
        repeat (500) begin
            @(negedge clock);
            if (tx !== 1'b1 || busy || fifo_read_en) bad++;
        end
        check("idle_quiet", 32'(bad), 32'd0);

        // reset mid-frame; the popped byte is lost
        write_byte(8'hA3, 1'b0);
        n = 0;
        while (!(in_frame && t == 34) && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("reach_mid_frame", 32'(n < 200), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        check("midreset_tx", 32'(tx), 32'd1);
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_read_en", 32'(fifo_read_en), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        check("midreset_empty", 32'(fifo_empty), 32'd1);
        write_byte(8'h3C, 1'b1);
        wait_done(400, "drain_3c");

        // fill to full while held in reset, then drain in order
        reset = 1'b1;
        for (int i = 0; i < DEPTH; i++) write_byte(8'(i), 1'b1);
        check("fill_full", 32'(fifo_full), 32'd1);
        p0    = pulses;
        reset = 1'b0;
        n     = 0;
        while (pulses == p0 && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("first_pop_seen", 32'(n < 50), 32'd1);
        repeat (2) @(negedge clock);
        check("full_after_pop", 32'(fifo_full), 32'd0);
        wait_done(DEPTH * (FRAME + 1) + 200, "drain_fill");
        check("fill_pulses", 32'(pulses - p0), 32'(DEPTH));

`ifdef FIFO_UART_TX_PARITY_EN
        write_byte(8'h07, 1'b1);
        wait_done(400, "drain_07");
        check("parity_07", 32'(last_par), 32'd1);
        check("len_parity", 32'(last_busy_len), 32'd110);
        write_byte(8'h03, 1'b1);
        wait_done(400, "drain_03");
        check("parity_03", 32'(last_par), 32'd0);
`endif

        check("read_en_spacing", 32'(viol), 32'd0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #800_000;
        $display("FAIL watchdog timeout checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Serial transmitter that drains the byte FIFO from its read side and sends each entry as an 8N1 UART frame on the Tang Nano 20K TX pin. It watches the FIFO `empty` flag, pops one entry per frame with a single-cycle `read_en` pulse (the FIFO pops on a rising edge of `read_en`), and shifts the byte out LSB-first. It sits between the FIFO and the board UART pin and is the consumer counterpart to whatever fills the FIFO.

## Interface
Parameters:
- `CLK_FREQ`, 27_000_000: clock frequency in Hz.
- `BAUD`, 115200: line rate in bit/s.
- `DATA_WIDTH`, 8: frame data bits; matches the FIFO `DATA_WIDTH`.

Ports:
- `clock` input 1: single clock domain, rising edge.
- `reset` input 1: synchronous, active-high.
- `fifo_empty` input 1: FIFO `empty` flag.
- `fifo_data` input DATA_WIDTH: FIFO `data_out`, showing the head entry combinationally.
- `fifo_read_en` output 1: pop request to FIFO `read_en`, one-cycle pulse.
- `tx` output 1: serial line; idle level is high.
- `busy` output 1: high while a frame is in progress.

## Operation
- Bit period `DIV = (CLK_FREQ + BAUD/2) / BAUD`, rounded to nearest. Elaboration fails if `DIV < 2`.
- Baud counter width is `$clog2(DIV)`. It counts 0..DIV-1 and is cleared on frame start, so there is no fractional-tick carry between frames.
- States:
  - IDLE: `tx`=1, `fifo_read_en`=0.
  - If `fifo_empty`=0, on the next edge: latch `fifo_data` into the shift register, set `fifo_read_en`=1, set `tx`=0, go to START.
- START: `fifo_read_en` returns to 0 on the next edge. After DIV cycles, go to DATA with bit index 0.
- DATA: `tx` = shift[index], LSB first. Each bit lasts DIV cycles. After bit DATA_WIDTH-1, go to PARITY (when enabled) or STOP.
- STOP: `tx`=1 for DIV cycles, then go to IDLE.
- `busy` = (state != IDLE), registered together with the state.
- Pulse spacing: `fifo_read_en` is never high on two consecutive cycles, and is low for at least 1 cycle before every pulse. This is required by the FIFO's edge detect.
- Data is latched in the same edge that raises `fifo_read_en`, i.e. before the FIFO advances `read_ptr`.
- `fifo_empty` is sampled only in IDLE. Changes during a frame are ignored.
- Reset mid-frame: on the next edge `tx`=1, `fifo_read_en`=0, `busy`=0, state=IDLE. The partial frame is abandoned and the popped byte is lost.

## Timing
- Reset values: `tx`=1, `fifo_read_en`=0, `busy`=0, state IDLE, counters 0.
- Start of frame: `fifo_empty` low at edge k gives `tx` low, `fifo_read_en` high and `busy` high during cycle k+1. `fifo_read_en` is low again from k+2.
- The first pop after reset release occurs no earlier than the first edge after release. `fifo_read_en` is held low through reset.
- Frame length: (DATA_WIDTH+2)·DIV cycles, or (DATA_WIDTH+3)·DIV with parity.
- One IDLE cycle between back-to-back frames. Minimum frame-to-frame period is frame length + 1.
- Throughput is limited by the line rate. The FIFO updates `empty` one cycle after the pop, well before the next IDLE sample.

## Configuration
- `FIFO_UART_TX_PARITY_EN`:
  - Defined: a PARITY state is inserted between DATA and STOP. `tx` = XOR of the latched data bits (even parity) for DIV cycles, giving 8E1.
  - Undefined: no PARITY state, no parity logic, 8N1.

## Structure
- Shared package `uart_pkg`:
  - State enum (IDLE, START, DATA, PARITY, STOP).
  - Function computing DIV from CLK_FREQ/BAUD.
  - Idle-level constant `UART_IDLE = 1'b1`.
- Sub-module `uart_baud_gen`: counter with synchronous `clear`, emitting a one-cycle `tick` every DIV cycles. The FSM advances on `tick`.

## Test plan
Bench setup: CLK_FREQ=1_000_000, BAUD=100_000 (DIV=10), connected to a real `fifo` DEPTH=16.
- Write 0x55 into the FIFO, then idle → one `fifo_read_en` pulse.
  - `tx` gives: start low 10 cycles, bits 1,0,1,0,1,0,1,0 at 10 cycles each, stop high 10 cycles.
  - `busy` high for exactly 100 cycles. FIFO `empty`=1 afterwards.
- Write 0x01, 0x80, 0xFF back-to-back → three frames decoded in order.
  - Start-bit falling edges 101 cycles apart.
  - Exactly three `fifo_read_en` pulses, each 1 cycle wide with low between.
- FIFO empty for 500 cycles → `tx`=1, `busy`=0, `fifo_read_en`=0 throughout.
- Assert `reset` 1 cycle at cycle 35 of a 0xA3 frame.
  - Next edge: `tx`=1, `busy`=0.
  - A following write of 0x3C is sent cleanly and decoded as 0x3C.
- Fill FIFO to 16 entries (0x00..0x0F) → all 16 bytes received in order and FIFO `full` deasserts after the first pop.
- With `FIFO_UART_TX_PARITY_EN` defined, send 0x07 → parity bit 1 and frame length 110 cycles. Send 0x03 → parity bit 0.
